// File: rtl/iddrx4b_deser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : iddrx4b_deser
//  Description : 1:8 input deserializer and word aligner on ECLK. Collects the
//                DR/DF bit pair from the pad DDR cell each edge, assembles
//                8-bit words (Q[0] earliest) and supports a one-bit slip of
//                the word boundary with a lockout window after each slip.
//  Revision    : 1.0 - initial release
// ============================================================================
module iddrx4b_deser #(
    parameter int unsigned SLIP_LOCKOUT = 4,
    parameter logic [7:0]  Q_RESET      = 8'h00
) (
    input  logic       ECLK,
    input  logic       RSTN,
    input  logic       DR,
    input  logic       DF,
    input  logic       ALIGNWD,
    output logic [7:0] Q,
    output logic       QVALID,
    output logic [2:0] SLIPCNT,
    output logic       ALIGNBUSY
);

    localparam logic [3:0] c_LOCKOUT = SLIP_LOCKOUT[3:0];

    // Pair captured at the previous edge; processed one edge later so that
    // Q/QVALID appear one cycle after the word's last bit is sampled.
    logic       r_dr;
    logic       r_df;
    logic       r_pvld;

    // Partial word under construction: r_acc[0..r_cnt-1] hold collected bits.
    logic [7:0] r_acc;
    logic [2:0] r_cnt;
    logic       r_skip;     // drop the next incoming stream bit

    // Slip control: r_slip is an accepted slip awaiting application.
    logic       r_slip;
    logic [3:0] r_lock;

    logic [7:0] w_acc;
    logic [2:0] w_cnt;
    logic       w_skip;
    logic       w_done;
    logic [7:0] w_word;
    logic [1:0] w_bits;
    logic       w_accept;

    assign w_bits   = {r_df, r_dr};
    assign w_accept = ALIGNWD && (r_lock == 4'd0);

    // Insert the held pair bit by bit (earliest first), emit a completed word,
    // then apply a pending slip by discarding the first bit of the next word.
    always_comb begin
        w_acc  = r_acc;
        w_cnt  = r_cnt;
        w_skip = r_skip;
        w_done = 1'b0;
        w_word = r_acc;
        if (r_pvld) begin
            for (int i = 0; i < 2; i++) begin
                if (w_skip) begin
                    w_skip = 1'b0;
                end else begin
                    w_acc[w_cnt] = w_bits[i];
                    if (w_cnt == 3'd7) begin
                        w_done = 1'b1;
                        w_word = w_acc;
                        w_cnt  = 3'd0;
                    end else begin
                        w_cnt = w_cnt + 3'd1;
                    end
                end
            end
            if (r_slip) begin
                // Nothing collected yet for the next word: skip its first
                // bit when it arrives instead.
                if (w_cnt != 3'd0) begin
                    w_acc = {1'b0, w_acc[7:1]};
                    w_cnt = w_cnt - 3'd1;
                end else begin
                    w_skip = 1'b1;
                end
            end
        end
    end

    // Capture the pad pair and advance the word assembly state.
    always_ff @(posedge ECLK or negedge RSTN) begin
        if (!RSTN) begin
            r_dr   <= 1'b0;
            r_df   <= 1'b0;
            r_pvld <= 1'b0;
            r_acc  <= 8'h00;
            r_cnt  <= 3'd0;
            r_skip <= 1'b0;
            Q      <= Q_RESET;
            QVALID <= 1'b0;
        end else begin
            r_dr   <= DR;
            r_df   <= DF;
            r_pvld <= 1'b1;
            r_acc  <= w_acc;
            r_cnt  <= w_cnt;
            r_skip <= w_skip;
            QVALID <= w_done;
            if (w_done) begin
                Q <= w_word;
            end
        end
    end

    // Accept slips outside the lockout window; report offset and busy one
    // edge after acceptance so they line up with the applied slip.
    always_ff @(posedge ECLK or negedge RSTN) begin
        if (!RSTN) begin
            r_slip    <= 1'b0;
            r_lock    <= 4'd0;
            SLIPCNT   <= 3'd0;
            ALIGNBUSY <= 1'b0;
        end else begin
            r_slip    <= w_accept;
            ALIGNBUSY <= (r_lock != 4'd0);
            if (w_accept) begin
                r_lock <= c_LOCKOUT;
            end else if (r_lock != 4'd0) begin
                r_lock <= r_lock - 4'd1;
            end
            if (r_slip) begin
                SLIPCNT <= SLIPCNT + 3'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iddrx4b_deser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_iddrx4b_deser
//  Description : Directed self-checking bench for iddrx4b_deser using a
//                repeating 0xB4 LSB-first stream and scheduled ALIGNWD pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iddrx4b_deser;

    localparam int         SLIP_LOCKOUT = 4;
    localparam logic [7:0] Q_RST        = 8'h00;

    logic       ECLK    = 1'b0;
    logic       RSTN    = 1'b0;
    logic       DR      = 1'b0;
    logic       DF      = 1'b0;
    logic       ALIGNWD = 1'b0;
    logic [7:0] Q;
    logic       QVALID;
    logic [2:0] SLIPCNT;
    logic       ALIGNBUSY;

    iddrx4b_deser #(
        .SLIP_LOCKOUT (SLIP_LOCKOUT),
        .Q_RESET      (Q_RST)
    ) u_dut (
        .ECLK      (ECLK),
        .RSTN      (RSTN),
        .DR        (DR),
        .DF        (DF),
        .ALIGNWD   (ALIGNWD),
        .Q         (Q),
        .QVALID    (QVALID),
        .SLIPCNT   (SLIPCNT),
        .ALIGNBUSY (ALIGNBUSY)
    );

    always #5 ECLK = ~ECLK;

    // 0xB4 LSB-first: (DR,DF) per edge = (0,0),(1,0),(1,1),(0,1)
    logic [3:0] dr_pat = 4'b0110;
    logic [3:0] df_pat = 4'b1100;

    int n_total = 0;
    int n_bad   = 0;
    int e;

    logic       aw_sched [0:127];
    logic       rec_qv   [0:127];
    logic [7:0] rec_q    [0:127];
    logic [2:0] rec_sc   [0:127];
    logic       rec_bz   [0:127];

    int ve[$];
    int vq[$];
    int exp_e[$];
    int exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge ECLK);
        RSTN    = 1'b0;
        DR      = 1'b0;
        DF      = 1'b0;
        ALIGNWD = 1'b0;
        @(negedge ECLK);
        #1;
        chk("rst_q", {24'd0, Q}, {24'd0, Q_RST});
        chk("rst_qvalid", {31'd0, QVALID}, 32'd0);
        chk("rst_slipcnt", {29'd0, SLIPCNT}, 32'd0);
        chk("rst_busy", {31'd0, ALIGNBUSY}, 32'd0);
        for (int i = 0; i < 128; i++) aw_sched[i] = 1'b0;
        @(posedge ECLK);
        #2;
        RSTN = 1'b1;
        e    = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge ECLK);
            DR      = dr_pat[e % 4];
            DF      = df_pat[e % 4];
            ALIGNWD = aw_sched[e];
            @(posedge ECLK);
            #1;
            rec_qv[e] = QVALID;
            rec_q[e]  = Q;
            rec_sc[e] = SLIPCNT;
            rec_bz[e] = ALIGNBUSY;
            e++;
        end
    endtask

    task automatic collect();
        ve.delete();
        vq.delete();
        for (int i = 0; i < e; i++) begin
            if (rec_qv[i]) begin
                ve.push_back(i);
                vq.push_back(int'(rec_q[i]));
            end
        end
    endtask

    task automatic check_words(input string tag);
        collect();
        chk({tag, "_nwords"}, ve.size(), exp_e.size());
        for (int i = 0; i < ve.size() && i < exp_e.size(); i++) begin
            chk($sformatf("%s_edge%0d", tag, i), ve[i], exp_e[i]);
            chk($sformatf("%s_q%0d", tag, i), vq[i], exp_q[i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int first;
        int c5;
        int cother;
        int seq[$];
        int sce[$];
        int scv[$];
        int exp_seq[$];

        // ---------------- basic deserialization ----------------
        do_reset();
        run(20);
        exp_e = '{4, 8, 12, 16};
        exp_q = '{8'hB4, 8'hB4, 8'hB4, 8'hB4};
        check_words("basic");
        chk("basic_q_before_first", {24'd0, rec_q[3]}, {24'd0, Q_RST});
        cnt = 0;
        for (int i = 0; i < e; i++) if (rec_sc[i] != 3'd0 || rec_bz[i]) cnt++;
        chk("basic_ctrl_idle", cnt, 0);

        // ---------------- single slip ----------------
        do_reset();
        aw_sched[10] = 1'b1;
        run(32);
        exp_e = '{4, 8, 13, 17, 21, 25, 29};
        exp_q = '{8'hB4, 8'hB4, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
        check_words("slip1");
        chk("slip1_sc_before", {29'd0, rec_sc[10]}, 32'd0);
        chk("slip1_sc_after", {29'd0, rec_sc[11]}, 32'd1);
        chk("slip1_sc_end", {29'd0, rec_sc[31]}, 32'd1);
        cnt   = 0;
        first = -1;
        for (int i = 0; i < e; i++) begin
            if (rec_bz[i]) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        chk("slip1_busy_first", first, 11);
        chk("slip1_busy_len", cnt, 4);

        // ---------------- full slip cycle ----------------
        do_reset();
        for (int k = 0; k < 8; k++) aw_sched[10 + 12 * k] = 1'b1;
        run(112);
        collect();
        seq.delete();
        for (int i = 0; i < vq.size(); i++) begin
            if (seq.size() == 0 || seq[seq.size() - 1] != vq[i]) seq.push_back(vq[i]);
        end
        exp_seq = '{8'hB4, 8'h5A, 8'h2D, 8'h96, 8'h4B, 8'hA5, 8'hD2, 8'h69, 8'hB4};
        chk("cycle_nvals", seq.size(), exp_seq.size());
        for (int i = 0; i < seq.size() && i < exp_seq.size(); i++)
            chk($sformatf("cycle_val%0d", i), seq[i], exp_seq[i]);
        c5     = 0;
        cother = 0;
        for (int i = 1; i < ve.size(); i++) begin
            if (ve[i] - ve[i - 1] == 5) c5++;
            else if (ve[i] - ve[i - 1] != 4) cother++;
        end
        chk("cycle_gap5_count", c5, 4);
        chk("cycle_gap_other", cother, 0);
        sce.delete();
        scv.delete();
        for (int i = 1; i < e; i++) begin
            if (rec_sc[i] != rec_sc[i - 1]) begin
                sce.push_back(i);
                scv.push_back(int'(rec_sc[i]));
            end
        end
        chk("cycle_sc_nsteps", sce.size(), 8);
        for (int k = 0; k < sce.size() && k < 8; k++) begin
            chk($sformatf("cycle_sc_edge%0d", k), sce[k], 11 + 12 * k);
            chk($sformatf("cycle_sc_val%0d", k), scv[k], (k + 1) % 8);
        end

        // ---------------- held ALIGNWD with lockout ----------------
        do_reset();
        for (int i = 10; i < 30; i++) aw_sched[i] = 1'b1;
        run(40);
        sce.delete();
        for (int i = 1; i < e; i++) if (rec_sc[i] != rec_sc[i - 1]) sce.push_back(i);
        chk("held_nslips", sce.size(), 4);
        for (int k = 0; k < sce.size() && k < 4; k++)
            chk($sformatf("held_slip_edge%0d", k), sce[k], 11 + 5 * k);
        chk("held_sc_end", {29'd0, rec_sc[39]}, 32'd4);
        cnt = 0;
        for (int i = 0; i < e; i++) if (rec_bz[i]) cnt++;
        chk("held_busy_total", cnt, 16);
        collect();
        chk("held_last_q", (vq.size() > 0) ? vq[vq.size() - 1] : -1, 8'h4B);

        // ---------------- reset mid-word ----------------
        do_reset();
        aw_sched[0] = 1'b1;
        run(11);
        chk("midrst_sc_pre", {29'd0, rec_sc[10]}, 32'd1);
        RSTN = 1'b0;
        #0.5;
        chk("midrst_q", {24'd0, Q}, {24'd0, Q_RST});
        chk("midrst_slipcnt", {29'd0, SLIPCNT}, 32'd0);
        chk("midrst_qvalid", {31'd0, QVALID}, 32'd0);
        chk("midrst_busy", {31'd0, ALIGNBUSY}, 32'd0);
        #0.5;
        RSTN = 1'b1;
        for (int i = 0; i < 128; i++) aw_sched[i] = 1'b0;
        e = 0;
        run(12);
        exp_e = '{4, 8};
        exp_q = '{8'hB4, 8'hB4};
        check_words("midrst");
        chk("midrst_q_hold", {24'd0, rec_q[3]}, {24'd0, Q_RST});
        chk("midrst_sc_after", {29'd0, rec_sc[11]}, 32'd0);

        // ---------------- slip on emission edge ----------------
        do_reset();
        aw_sched[7] = 1'b1;
        run(24);
        exp_e = '{4, 8, 13, 17, 21};
        exp_q = '{8'hB4, 8'hB4, 8'h5A, 8'h5A, 8'h5A};
        check_words("emslip");
        chk("emslip_sc", {29'd0, rec_sc[23]}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iddrx4b_deser.md
Name: iddrx4b_deser

Overview:
- 1:8 input deserializer and word aligner. It is the receive-side counterpart of the team's 8:1 x4 output gearbox.
- Takes the two bits per ECLK cycle captured by the pad DDR input cell (rising-edge bit DR, falling-edge bit DF) and assembles them into 8-bit words.
- Provides an ALIGNWD bit-slip so fabric training logic can move the word boundary one bit at a time.
- Runs entirely on ECLK; the word-valid strobe replaces a separate SCLK domain.

Parameters:
- SLIP_LOCKOUT, 4: number of ECLK edges after an accepted slip during which ALIGNWD is ignored. Legal range 1..15.
- Q_RESET, 8'h00: value Q takes under reset.

Ports:
- ECLK  input  1  edge clock; all state updates on its rising edge.
- RSTN  input  1  asynchronous active-low reset.
- DR  input  1  serial bit captured at pad on ECLK rising edge (earlier bit of the pair).
- DF  input  1  serial bit captured at pad on ECLK falling edge (later bit of the pair).
- ALIGNWD  input  1  bit-slip request, sampled on ECLK rising edge.
- Q  output  8  deserialized word; Q[0] is the earliest bit in time.
- QVALID  output  1  one-cycle strobe; Q holds a new word.
- SLIPCNT  output  3  current bit offset o (0..7).
- ALIGNBUSY  output  1  high while slip lockout is active.

Behaviour:
- Reset (RSTN low, asynchronous), outputs: Q=Q_RESET, QVALID=0, SLIPCNT=0, ALIGNBUSY=0.
- Reset, internal state: history, phase and lockout counters all cleared; any partial word is discarded.
- Edge numbering: the first ECLK rising edge with RSTN high is edge 0. The pair sampled at edge n forms stream bits b(2n)=DR and b(2n+1)=DF.
- Word definition: with offset o, word j = b(8j+o) .. b(8j+o+7), and Q[i] = b(8j+o+i).
- Emission timing:
  - A word's last bit is sampled at edge n = floor((8j+o+7)/2).
  - Q and QVALID update at edge n+1 (registered, 1-cycle latency). QVALID is high for exactly that one cycle.
  - Q holds its value between strobes.
- Steady state: QVALID pulses every 4 cycles. The first word after reset is b0..b7, with QVALID at edge 4.
- Slip acceptance: if ALIGNWD=1 at edge n and ALIGNBUSY=0, the slip is accepted.
  - o <= (o+1) mod 8, and SLIPCNT updates at edge n+1.
  - ALIGNBUSY=1 for edges n+1..n+SLIP_LOCKOUT; ALIGNWD is ignored during that window.
- Slip effect on the word stream:
  - Words whose last bit is sampled at or before edge n use the old offset.
  - The next word starts one bit later than it otherwise would, so exactly one stream bit is dropped.
  - Going from an even to an odd o stretches one QVALID gap to 5 cycles. Going from odd to even, including the 7->0 wrap, keeps the gap at 4 cycles.
- Slip coinciding with emission: ALIGNWD accepted on the same edge a word completes does not corrupt or suppress that word.
- ALIGNWD held high: one slip accepted every SLIP_LOCKOUT+1 edges.
- No slip is lost or doubled because ALIGNWD is held longer than one cycle.
- X on DR/DF propagates into the corresponding Q bits only. Control state is unaffected.

Test Plan:
- Basic deserialization:
  - Stimulus: reset, then repeat byte 0xB4 LSB-first. Pairs (DR,DF) per edge are (0,0),(1,0),(1,1),(0,1).
  - Required: QVALID at edges 4, 8, 12, ...; Q=8'hB4 each time; SLIPCNT=0; ALIGNBUSY=0.
- Single slip:
  - Stimulus: same 0xB4 stream, one-cycle ALIGNWD pulse.
  - Required: SLIPCNT=1; one QVALID gap of 5 cycles; all following words Q=8'h5A; ALIGNBUSY high for exactly 4 cycles.
- Full slip cycle:
  - Stimulus: eight spaced ALIGNWD pulses on the 0xB4 stream.
  - Required: Q sequence 5A, 2D, 96, 4B, A5, D2, 69, B4; SLIPCNT steps 1..7 then wraps to 0; gaps alternate 5 and 4 cycles.
- Held ALIGNWD with lockout:
  - Stimulus: ALIGNWD high for 20 consecutive edges, SLIP_LOCKOUT=4.
  - Required: slips accepted at edges k, k+5, k+10, k+15; SLIPCNT ends at 4.
- Reset mid-word:
  - Stimulus: assert RSTN low for 1 ns after edge 2 of a word.
  - Required: Q=Q_RESET and SLIPCNT=0 immediately; no QVALID for the partial word; next QVALID at edge 4 after release with a clean word.
- Slip on emission edge:
  - Stimulus: ALIGNWD accepted on the edge where word j completes.
  - Required: word j emitted intact with the old offset; word j+1 reflects the new offset.
